seq_scan_ctrl: RTL and testbench

Controller that sequences a serial pattern detector across a framed stream of parallel words. It accepts words over a valid/ready handshake, serializes each MSB-first into an internal programmable-pattern matcher, and counts matches across the whole frame. At end of frame it reports the count over a second valid/ready handshake. It sits between a parallel data source and downstream match-statistics logic. Pattern and overlap mode are configurable, and the reset default reproduces a 1010 overlapping detector.

---
 rtl/seq_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_seq_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_scan_ctrl: serializes framed words into a pattern matcher and        |
// | reports the saturating per-frame match count.   Rev 1.0                  |
// +--------------------------------------------------------------------------+
module seq_scan_ctrl #(
  parameter int DATA_W = 8,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              ser_bit,
  output logic              ser_en,
  output logic              match,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int HW = $clog2(PAT_W + 1);
  localparam logic [31:0]      PAT_SEED = 32'hA;
  localparam logic [PAT_W-1:0] PAT_RST  = PAT_SEED[PAT_W-1:0];
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [HW:0]      PAT_LEN  = (HW+1)'(PAT_W);
  localparam logic [HW-1:0]    HCNT_MAX = HW'(PAT_W);
  localparam logic [BW-1:0]    LAST_BIT = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              last_q, last_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [HW-1:0]     hcnt_q, hcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              ovl_q, ovl_d;
  logic              ser_bit_q, ser_bit_d;
  logic              ser_en_q, ser_en_d;
  logic              match_q, match_d;

  logic              w_bit;
  logic [PAT_W-1:0]  w_win;
  logic              w_hit;

  // The window only counts once enough history (including this bit) exists.
  assign w_bit = shreg_q[DATA_W-1];
  assign w_win = {hist_q, w_bit};
  assign w_hit = (({1'b0, hcnt_q} + (HW+1)'(1)) >= PAT_LEN) && (w_win == pat_q);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    last_d    = last_q;
    bit_cnt_d = bit_cnt_q;
    hist_d    = hist_q;
    hcnt_d    = hcnt_q;
    cnt_d     = cnt_q;
    pat_d     = pat_q;
    ovl_d     = ovl_q;
    ser_bit_d = ser_bit_q;
    ser_en_d  = 1'b0;
    match_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          pat_d = cfg_pat;
          ovl_d = cfg_overlap;
        end
        if (in_valid) begin
          shreg_d   = in_data;
          last_d    = in_last;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
        hist_d    = w_win[PAT_W-2:0];
        hcnt_d    = (hcnt_q == HCNT_MAX) ? hcnt_q : hcnt_q + HW'(1);
        ser_bit_d = w_bit;
        ser_en_d  = 1'b1;
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (w_hit) begin
          match_d = 1'b1;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (!ovl_q) hcnt_d = '0;
        end
        if (bit_cnt_q == LAST_BIT) state_d = last_q ? ST_REPORT : ST_IDLE;
      end
      ST_REPORT: begin
        if (out_ready) begin
          cnt_d   = '0;
          hist_d  = '0;
          hcnt_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      last_q    <= 1'b0;
      bit_cnt_q <= '0;
      hist_q    <= '0;
      hcnt_q    <= '0;
      cnt_q     <= '0;
      pat_q     <= PAT_RST;
      ovl_q     <= 1'b1;
      ser_bit_q <= 1'b0;
      ser_en_q  <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      last_q    <= last_d;
      bit_cnt_q <= bit_cnt_d;
      hist_q    <= hist_d;
      hcnt_q    <= hcnt_d;
      cnt_q     <= cnt_d;
      pat_q     <= pat_d;
      ovl_q     <= ovl_d;
      ser_bit_q <= ser_bit_d;
      ser_en_q  <= ser_en_d;
      match_q   <= match_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_REPORT);
  assign out_count = cnt_q;
  assign ser_bit   = ser_bit_q;
  assign ser_en    = ser_en_q;
  assign match     = match_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_scan_ctrl: directed self-checking bench for seq_scan_ctrl.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_pat = 4'b0000;
  logic       cfg_overlap = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic       ser_bit, ser_en, match;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_count;
  logic       busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_scan_ctrl #(.DATA_W(8), .PAT_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_overlap(cfg_overlap),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .ser_bit(ser_bit), .ser_en(ser_en), .match(match),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .busy(busy)
  );

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = in_ready;
  endtask

  task automatic send_word(input logic [7:0] d, input logic l, output bit ok);
    wait_ready(ok);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    ok = out_valid;
  endtask

  task automatic accept_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic write_cfg(input logic [3:0] p, input logic o);
    cfg_we = 1'b1;
    cfg_pat = p;
    cfg_overlap = o;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // One AA word with last=1; checks bit-level timing and the reported count.
  task automatic run_aa_frame(input string name, input logic [7:0] exp_m, input logic [3:0] exp_cnt);
    bit ok;
    logic [7:0] m, s;
    bit en_ok = 1'b1;
    send_word(8'hAA, 1'b1, ok);
    checks++;
    if (ok !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s accept got ok=%0b busy=%0b in_ready=%0b out_valid=%0b exp 1 1 0 0", name, ok, busy, in_ready, out_valid);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      m[7-k] = match;
      s[7-k] = ser_bit;
      if (ser_en !== 1'b1) en_ok = 1'b0;
    end
    checks++;
    if (m !== exp_m) begin
      failures++;
      $display("FAIL %s match_bits got=%h exp=%h", name, m, exp_m);
    end
    checks++;
    if (s !== 8'hAA || en_ok !== 1'b1) begin
      failures++;
      $display("FAIL %s ser_bits got=%h en_ok=%0b exp=aa en_ok=1", name, s, en_ok);
    end
    checks++;
    if (out_valid !== 1'b1 || out_count !== exp_cnt) begin
      failures++;
      $display("FAIL %s result got valid=%0b count=%0d exp valid=1 count=%0d", name, out_valid, out_count, exp_cnt);
    end
    accept_result();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || ser_en !== 1'b0) begin
      failures++;
      $display("FAIL %s release got valid=%0b in_ready=%0b ser_en=%0b exp 0 1 0", name, out_valid, in_ready, ser_en);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready got=%0b exp=1", in_ready); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset busy got=%0b exp=0", busy); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid got=%0b exp=0", out_valid); end
    checks++;
    if (match !== 1'b0 || ser_en !== 1'b0) begin failures++; $display("FAIL reset match/ser_en got=%0b/%0b exp=0/0", match, ser_en); end
    checks++;
    if (out_count !== 4'd0) begin failures++; $display("FAIL reset out_count got=%0d exp=0", out_count); end
  endtask

  task automatic test_default_overlap();
    run_aa_frame("default_overlap", 8'h15, 4'd3);
  endtask

  task automatic test_no_overlap();
    write_cfg(4'b1010, 1'b0);
    run_aa_frame("no_overlap", 8'h11, 4'd2);
  endtask

  task automatic test_cross_word();
    bit ok1, ok2, ok3;
    write_cfg(4'b1010, 1'b1);
    send_word(8'h05, 1'b0, ok1);
    send_word(8'h00, 1'b1, ok2);
    @(negedge clk);
    checks++;
    if (ok1 !== 1'b1 || ok2 !== 1'b1 || match !== 1'b1 || ser_bit !== 1'b0) begin
      failures++;
      $display("FAIL cross_word first_bit got ok=%0b%0b match=%0b ser_bit=%0b exp 11 1 0", ok1, ok2, match, ser_bit);
    end
    wait_out(ok3);
    checks++;
    if (ok3 !== 1'b1 || out_count !== 4'd1) begin
      failures++;
      $display("FAIL cross_word count got valid=%0b count=%0d exp valid=1 count=1", ok3, out_count);
    end
    accept_result();
  endtask

  task automatic test_saturation();
    bit ok;
    bit all_ok = 1'b1;
    for (int w = 0; w < 6; w++) begin
      send_word(8'hAA, (w == 5), ok);
      if (!ok) all_ok = 1'b0;
    end
    wait_out(ok);
    checks++;
    if (all_ok !== 1'b1 || ok !== 1'b1 || out_count !== 4'd15) begin
      failures++;
      $display("FAIL saturation got sends_ok=%0b valid=%0b count=%0d exp 1 1 15", all_ok, ok, out_count);
    end
  endtask

  // Entered with the saturated result still pending in REPORT.
  task automatic test_backpressure();
    bit ok;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin
        cfg_we = 1'b1;
        cfg_pat = 4'b1111;
        cfg_overlap = 1'b0;
      end
      @(negedge clk);
      cfg_we = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || out_count !== 4'd15 || in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL backpressure cyc%0d got valid=%0b count=%0d in_ready=%0b busy=%0b exp 1 15 0 1", c, out_valid, out_count, in_ready, busy);
      end
    end
    accept_result();
    send_word(8'hAA, 1'b1, ok);
    wait_out(ok);
    checks++;
    if (ok !== 1'b1 || out_count !== 4'd3) begin
      failures++;
      $display("FAIL cfg_ignored got valid=%0b count=%0d exp valid=1 count=3", ok, out_count);
    end
    accept_result();
  endtask

  task automatic test_reset_mid_shift();
    bit ok;
    bit stray = 1'b0;
    write_cfg(4'b0110, 1'b1);
    send_word(8'hAA, 1'b1, ok);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || match !== 1'b0 || ser_en !== 1'b0 || out_count !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_shift got in_ready=%0b busy=%0b valid=%0b match=%0b ser_en=%0b count=%0d exp 1 0 0 0 0 0",
               in_ready, busy, out_valid, match, ser_en, out_count);
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin failures++; $display("FAIL reset_no_result got stray_valid=%0b exp=0", stray); end
    send_word(8'hAA, 1'b1, ok);
    wait_out(ok);
    checks++;
    if (ok !== 1'b1 || out_count !== 4'd3) begin
      failures++;
      $display("FAIL reset_pat_default got valid=%0b count=%0d exp valid=1 count=3", ok, out_count);
    end
    accept_result();
  endtask

  initial begin
    test_reset();
    test_default_overlap();
    test_no_overlap();
    test_cross_word();
    test_saturation();
    test_backpressure();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
